if_stage: RTL and testbench

Instruction-fetch stage of the five-stage turbo RISC-V pipeline, directly upstream of the decode stage. Holds the PC, issues single-outstanding requests to instruction memory over a valid/ready handshake, and hands `{pc, inst}` to decode through the `if_to_id_valid` / `id_allowin` handshake. Applies redirects from decode (jumps and predicted branches) and from execute (mispredict cancel), and discards any in-flight fetch those redirects make stale.

---
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request, decode handoff, redirect handling.
// Optional IF_PERF_CNT_EN adds handoff / discarded-response counters.
module if_stage #(
   parameter logic [31:0] RESET_PC         = 32'h0000_0000,
   parameter int          BR_WD            = 33,
   parameter int          IF_TO_ID_DATA_WD = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        inst_req_valid,
   input  logic                        inst_req_ready,
   output logic [31:0]                 inst_addr,
   input  logic                        inst_valid,
   input  logic [31:0]                 inst_rdata,
   input  logic [BR_WD-1:0]            br_info,
   input  logic                        id_br_valid,
   input  logic                        cancle,
   input  logic [31:0]                 cancle_target,
   input  logic                        id_allowin,
   output logic                        if_to_id_valid,
   output logic [IF_TO_ID_DATA_WD-1:0] if_to_id_data
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]                 perf_fetch_cnt,
   output logic [31:0]                 perf_drop_cnt
`endif
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   logic [1:0]                  state;
   logic [1:0]                  state_nxt;
   logic [31:0]                 pc;
   logic [31:0]                 pc_nxt;
   logic [IF_TO_ID_DATA_WD-1:0] data_q;
   logic                        load_data;
   logic                        redirect;
   logic [31:0]                 redirect_target;

   // Execute flush outranks a decode-stage branch/jump.
   assign redirect        = cancle | (id_br_valid & br_info[BR_WD-1]);
   assign redirect_target = cancle ? cancle_target : br_info[31:0];

   assign inst_req_valid = rst & (state == S_REQ);
   assign inst_addr      = {pc[31:2], 2'b00};
   assign if_to_id_valid = (state == S_HOLD);
   assign if_to_id_data  = data_q;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      load_data = 1'b0;
      case (state)
         S_REQ: begin
            // An accepted address cannot be withdrawn, so its response must be dropped.
            if (inst_req_ready) state_nxt = redirect ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (inst_valid) begin
               if (redirect) begin
                  state_nxt = S_REQ;
               end else begin
                  state_nxt = S_HOLD;
                  load_data = 1'b1;
               end
            end else if (redirect) begin
               state_nxt = S_DROP;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               state_nxt = S_REQ;
            end else if (id_allowin) begin
               state_nxt = S_REQ;
               pc_nxt    = pc + 32'd4;
            end
         end
         S_DROP: begin
            if (inst_valid) state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
      if (redirect) pc_nxt = redirect_target;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_REQ;
         pc     <= RESET_PC;
         data_q <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (load_data) data_q <= {pc, inst_rdata};
      end
   end

`ifdef IF_PERF_CNT_EN
   logic fetch_evt;
   logic drop_evt;

   assign fetch_evt = (state == S_HOLD) & ~redirect & id_allowin;
   // Every response that never reaches decode, plus held instructions killed by a redirect.
   assign drop_evt  = (inst_valid & (((state == S_WAIT) & redirect) | (state == S_DROP)))
                    | ((state == S_HOLD) & redirect);

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_fetch_cnt <= '0;
         perf_drop_cnt  <= '0;
      end else begin
         if (fetch_evt) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (drop_evt)  perf_drop_cnt  <= perf_drop_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios plus randomized traffic against a transaction-level model.
// Perf counter checks are active when IF_PERF_CNT_EN is defined.
module tb_if_stage;

   localparam logic [31:0] RST_PC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req_valid;
   logic        inst_req_ready;
   logic [31:0] inst_addr;
   logic        inst_valid;
   logic [31:0] inst_rdata;
   logic [32:0] br_info;
   logic        id_br_valid;
   logic        cancle;
   logic [31:0] cancle_target;
   logic        id_allowin;
   logic        if_to_id_valid;
   logic [63:0] if_to_id_data;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_drop_cnt;
`endif

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .inst_req_valid (inst_req_valid),
      .inst_req_ready (inst_req_ready),
      .inst_addr      (inst_addr),
      .inst_valid     (inst_valid),
      .inst_rdata     (inst_rdata),
      .br_info        (br_info),
      .id_br_valid    (id_br_valid),
      .cancle         (cancle),
      .cancle_target  (cancle_target),
      .id_allowin     (id_allowin),
      .if_to_id_valid (if_to_id_valid),
      .if_to_id_data  (if_to_id_data)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_drop_cnt  (perf_drop_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // Memory environment: one response, mem_lat cycles after acceptance.
   int mem_lat  = 1;
   bit mem_busy = 1'b0;
   int mem_cnt  = 0;

   // Reference: next fetch PC plus the fate of the one transaction in flight.
   logic [31:0] m_pc = RST_PC;
   bit          m_out = 1'b0;
   bit          m_live = 1'b0;
   bit          m_hold = 1'b0;
   logic [31:0] m_req_addr = '0;
   logic [63:0] m_held = '0;
   logic [31:0] m_fetch = '0;
   logic [31:0] m_drop = '0;

   logic [31:0] w0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      bit exp_rv;
      exp_rv = rst && !m_out && !m_hold;
      check_val("req_valid", inst_req_valid, exp_rv);
      if (exp_rv) check_val("inst_addr", inst_addr, {m_pc[31:2], 2'b00});
      check_val("out_valid", if_to_id_valid, m_hold);
      check_val("out_data", if_to_id_data, m_held);
`ifdef IF_PERF_CNT_EN
      check_val("perf_fetch", perf_fetch_cnt, m_fetch);
      check_val("perf_drop", perf_drop_cnt, m_drop);
`endif
   endtask

   task automatic model_step();
      bit          redir;
      logic [31:0] tgt;
      bit          acc;
      if (!rst) begin
         m_pc = RST_PC; m_out = 0; m_live = 0; m_hold = 0;
         m_held = '0; m_fetch = '0; m_drop = '0;
         return;
      end
      redir = cancle || (id_br_valid && br_info[32]);
      tgt   = cancle ? cancle_target : br_info[31:0];
      acc   = !m_out && !m_hold && inst_req_ready;
      if (m_hold) begin
         if (redir) begin
            m_hold = 0; m_drop++;
         end else if (id_allowin) begin
            m_hold = 0; m_fetch++; m_pc = m_pc + 32'd4;
         end
      end
      if (m_out && inst_valid) begin
         m_out = 0;
         if (m_live && !redir) begin
            m_hold = 1; m_held = {m_req_addr, inst_rdata};
         end else begin
            m_drop++;
         end
      end else if (m_out && redir) begin
         m_live = 0;
      end
      if (acc) begin
         m_out = 1; m_live = !redir; m_req_addr = m_pc;
      end
      if (redir) m_pc = tgt;
   endtask

   task automatic mem_step();
      if (!rst) begin
         mem_busy = 0;
      end else begin
         if (mem_busy) begin
            if (inst_valid) mem_busy = 0;
            else mem_cnt--;
         end
         if (inst_req_valid && inst_req_ready) begin
            mem_busy = 1; mem_cnt = mem_lat;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_all();
      model_step();
      mem_step();
      @(posedge clk);
      #1;
      inst_valid = mem_busy && (mem_cnt == 1);
      inst_rdata = $urandom;
   endtask

   task automatic quiet();
      cancle = 0; id_br_valid = 0; br_info = '0;
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (inst_req_valid) break;
         tick();
      end
      check_val(tag, inst_req_valid, 1);
   endtask

   task automatic wait_hold(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (if_to_id_valid) break;
         tick();
      end
      check_val(tag, if_to_id_valid, 1);
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = $urandom;
      case ($urandom_range(0, 7))
         0:       t = 32'hFFFF_FFFC;
         1:       t = t;
         default: t = t & 32'hFFFF_FFFC;
      endcase
      return t;
   endfunction

   initial begin
      rst = 0; inst_req_ready = 0; inst_valid = 0; inst_rdata = '0;
      br_info = '0; id_br_valid = 0; cancle = 0; cancle_target = '0; id_allowin = 0;
      repeat (2) @(posedge clk);
      #1;
      tick(); tick();
      check_val("rst_req_valid", inst_req_valid, 0);
      check_val("rst_out_valid", if_to_id_valid, 0);
      check_val("rst_out_data", if_to_id_data, 64'h0);

      // Zero-wait memory from reset release.
      rst = 1; inst_req_ready = 1; id_allowin = 1; mem_lat = 1;
      #1;
      check_val("t1_req0", inst_req_valid, 1);
      check_val("t1_addr0", inst_addr, 32'h1000);
      tick();
      w0 = inst_rdata;
      tick();
      check_val("t1_out_valid", if_to_id_valid, 1);
      check_val("t1_out_data", if_to_id_data, {32'h1000, w0});
      tick();
      check_val("t1_req1", inst_req_valid, 1);
      check_val("t1_addr1", inst_addr, 32'h1004);
      repeat (3) tick();
      check_val("t1_addr2", inst_addr, 32'h1008);

      // Decode stalls on an instruction at 0x2000.
      cancle = 1; cancle_target = 32'h2000; id_allowin = 0;
      tick();
      quiet();
      wait_hold("t2_hold");
      check_val("t2_pc", if_to_id_data[63:32], 32'h2000);
      repeat (5) begin
         tick();
         check_val("t2_stall_valid", if_to_id_valid, 1);
         check_val("t2_stall_pc", if_to_id_data[63:32], 32'h2000);
         check_val("t2_stall_noreq", inst_req_valid, 0);
      end
      id_allowin = 1;
      tick();
      check_val("t2_req", inst_req_valid, 1);
      check_val("t2_addr", inst_addr, 32'h2004);

      // Branch redirect while a slow fetch is outstanding.
      mem_lat = 3;
      tick();
      id_br_valid = 1; br_info = {1'b1, 32'h3000};
      tick();
      quiet();
      for (int i = 0; i < 10; i++) begin
         if (inst_req_valid) break;
         check_val("t3_no_valid", if_to_id_valid, 0);
         tick();
      end
      check_val("t3_req", inst_req_valid, 1);
      check_val("t3_addr", inst_addr, 32'h3000);

      // Flush and branch together in HOLD with decode ready.
      mem_lat = 1; id_allowin = 0;
      wait_hold("t4_hold");
      cancle = 1; cancle_target = 32'h4000;
      id_br_valid = 1; br_info = {1'b1, 32'h5000}; id_allowin = 1;
      tick();
      quiet();
      check_val("t4_no_valid", if_to_id_valid, 0);
      check_val("t4_req", inst_req_valid, 1);
      check_val("t4_addr", inst_addr, 32'h4000);

      // PC wrap at the top of the address space.
      id_allowin = 0; cancle = 1; cancle_target = 32'hFFFF_FFFC;
      tick();
      quiet();
      wait_hold("t5_hold");
      check_val("t5_pc", if_to_id_data[63:32], 32'hFFFF_FFFC);
      id_allowin = 1;
      tick();
      check_val("t5_req", inst_req_valid, 1);
      check_val("t5_addr", inst_addr, 32'h0000_0000);

      // Reset while a fetch is outstanding.
      mem_lat = 3;
      wait_req("t6_wait_req");
      tick();
      rst = 0;
      tick();
      check_val("t6_req_valid", inst_req_valid, 0);
      check_val("t6_out_valid", if_to_id_valid, 0);
      check_val("t6_out_data", if_to_id_data, 64'h0);
      rst = 1;
      #1;
      check_val("t6_req", inst_req_valid, 1);
      check_val("t6_addr", inst_addr, RST_PC);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         rst            = ($urandom_range(0, 299) != 0);
         inst_req_ready = ($urandom_range(0, 3) != 0);
         id_allowin     = ($urandom_range(0, 2) != 0);
         mem_lat        = $urandom_range(1, 4);
         cancle         = ($urandom_range(0, 19) == 0);
         cancle_target  = rand_target();
         id_br_valid    = ($urandom_range(0, 9) == 0);
         br_info        = {($urandom_range(0, 3) != 0), rand_target()};
         tick();
      end
      quiet();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
